// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/branch controller.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  // Global 2-bit saturating branch predictor states.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pred_state_t;

  // One saturating step of the predictor toward the resolved outcome.
  function automatic pred_state_t pred_step(input pred_state_t cur, input logic taken);
    pred_state_t nxt;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = WT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard/branch controller.
// The master modport is the pipeline datapath, the slave modport is the controller.
interface pipe_hazard_ctrl_if import pipe_pkg::*; #(
  parameter int CNT_W = 16
);

  // Inputs from the ID and EX stages.
  logic                  ID_Branch_i;
  logic [REG_ADDR_W-1:0] ID_RS1addr_i;
  logic [REG_ADDR_W-1:0] ID_RS2addr_i;
  logic [XLEN-1:0]       ID_PC_branch_i;
  logic                  EX_MemRead_i;
  logic [REG_ADDR_W-1:0] EX_RDaddr_i;
  logic                  EX_Branch_i;
  logic                  EX_Predict_Branch_i;
  logic                  EX_taken_i;
  logic [XLEN-1:0]       EX_PC_next_i;
  logic [XLEN-1:0]       EX_PC_branch_i;

  // Control and status outputs of the controller.
  logic                  pc_write_o;
  logic                  if_id_write_o;
  logic                  id_noop_o;
  logic                  if_id_flush_o;
  logic                  id_ex_flush_o;
  logic                  predict_taken_o;
  logic                  pc_redirect_o;
  logic [XLEN-1:0]       pc_redirect_addr_o;
  logic [CNT_W-1:0]      stall_cnt_o;
  logic [CNT_W-1:0]      mispredict_cnt_o;
  logic [1:0]            pred_state_o;

  modport master (
    output ID_Branch_i, ID_RS1addr_i, ID_RS2addr_i, ID_PC_branch_i,
           EX_MemRead_i, EX_RDaddr_i, EX_Branch_i, EX_Predict_Branch_i,
           EX_taken_i, EX_PC_next_i, EX_PC_branch_i,
    input  pc_write_o, if_id_write_o, id_noop_o, if_id_flush_o, id_ex_flush_o,
           predict_taken_o, pc_redirect_o, pc_redirect_addr_o,
           stall_cnt_o, mispredict_cnt_o, pred_state_o
  );

  modport slave (
    input  ID_Branch_i, ID_RS1addr_i, ID_RS2addr_i, ID_PC_branch_i,
           EX_MemRead_i, EX_RDaddr_i, EX_Branch_i, EX_Predict_Branch_i,
           EX_taken_i, EX_PC_next_i, EX_PC_branch_i,
    output pc_write_o, if_id_write_o, id_noop_o, if_id_flush_o, id_ex_flush_o,
           predict_taken_o, pc_redirect_o, pc_redirect_addr_o,
           stall_cnt_o, mispredict_cnt_o, pred_state_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  // Count qualifying cycles, holding once the maximum is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and branch controller for the 5-stage pipeline: load-use stalls,
// ID-stage branch prediction, EX-stage mispredict recovery, perf counters.
module pipe_hazard_ctrl import pipe_pkg::*; #(
  parameter int         CNT_W    = 16,
  parameter logic [1:0] PRED_RST = 2'b10
) (
  input logic               clk_i,
  input logic               rst_i,
  pipe_hazard_ctrl_if.slave bus
);

  pred_state_t pred_state;
  pred_state_t pred_next_state;
  logic        mispredict;
  logic        loaduse;
  logic        predict_taken;
  logic        stall_inc;
  logic        mispredict_inc;

  // Hazard conditions; x0 is hard-wired zero so it never creates a dependency.
  assign mispredict    = bus.EX_Branch_i & (bus.EX_Predict_Branch_i != bus.EX_taken_i);
  assign loaduse       = bus.EX_MemRead_i & (bus.EX_RDaddr_i != 5'd0) &
                         ((bus.EX_RDaddr_i == bus.ID_RS1addr_i) |
                          (bus.EX_RDaddr_i == bus.ID_RS2addr_i));
  assign predict_taken = pred_state[1];

  // A mispredict cycle counts only as a mispredict, never as a stall.
  assign stall_inc      = loaduse & ~mispredict;
  assign mispredict_inc = mispredict;

  // Predictor state register; trains on every resolved branch, stall or not.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pred_state <= pred_state_t'(PRED_RST);
    end else begin
      pred_state <= pred_next_state;
    end
  end

  // Predictor next state: saturating move toward the outcome of the EX branch.
  always_comb begin
    pred_next_state = pred_state;
    if (bus.EX_Branch_i) begin
      pred_next_state = pred_step(pred_state, bus.EX_taken_i);
    end else begin
      pred_next_state = pred_state;
    end
  end

  // Pipeline control, prioritised: reset, mispredict, load-use, predicted-taken branch.
  always_comb begin
    bus.pc_write_o         = 1'b1;
    bus.if_id_write_o      = 1'b1;
    bus.id_noop_o          = 1'b0;
    bus.if_id_flush_o      = 1'b0;
    bus.id_ex_flush_o      = 1'b0;
    bus.pc_redirect_o      = 1'b0;
    bus.pc_redirect_addr_o = 32'h0000_0000;
    if (rst_i) begin
      bus.if_id_flush_o = 1'b1;
      bus.id_ex_flush_o = 1'b1;
    end else if (mispredict) begin
      // The ID instruction is on the wrong path, so any load-use on it is moot.
      bus.if_id_flush_o      = 1'b1;
      bus.id_ex_flush_o      = 1'b1;
      bus.pc_redirect_o      = 1'b1;
      bus.pc_redirect_addr_o = bus.EX_taken_i ? bus.EX_PC_branch_i : bus.EX_PC_next_i;
    end else if (loaduse) begin
      // Freeze PC and IF/ID, inject a bubble into ID/EX; a branch in ID waits.
      bus.pc_write_o    = 1'b0;
      bus.if_id_write_o = 1'b0;
      bus.id_noop_o     = 1'b1;
    end else if (bus.ID_Branch_i && predict_taken) begin
      bus.pc_redirect_o      = 1'b1;
      bus.pc_redirect_addr_o = bus.ID_PC_branch_i;
      bus.if_id_flush_o      = 1'b1;
    end else begin
      bus.pc_write_o    = 1'b1;
      bus.if_id_write_o = 1'b1;
    end
  end

  assign bus.predict_taken_o = predict_taken;
  assign bus.pred_state_o    = pred_state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (stall_inc),
    .count (bus.stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (mispredict_inc),
    .count (bus.mispredict_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .PRED_RST(2'b10)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state: predictor as a number 0..3, counters as plain ints.
  int m_pred  = 2;
  int m_scnt  = 0;
  int m_mcnt  = 0;
  int nx_pred = 2;
  int nx_scnt = 0;
  int nx_mcnt = 0;

  int exp_t [4] = '{2, 3, 3, 3};
  int exp_n [5] = '{2, 1, 0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: derive every output from the rules and the model state.
  always @(negedge clk) begin : cmp
    bit mp, lu, pt;
    bit e_pcw, e_ifw, e_noop, e_f1, e_f2, e_red;
    logic [31:0] e_addr;
    if (rst) begin
      m_pred = 2; m_scnt = 0; m_mcnt = 0;
    end
    mp = bus.EX_Branch_i && (bus.EX_Predict_Branch_i != bus.EX_taken_i);
    lu = bus.EX_MemRead_i && (bus.EX_RDaddr_i != 0) &&
         ((bus.EX_RDaddr_i == bus.ID_RS1addr_i) || (bus.EX_RDaddr_i == bus.ID_RS2addr_i));
    pt = (m_pred >= 2);
    e_pcw = 1; e_ifw = 1; e_noop = 0; e_f1 = 0; e_f2 = 0; e_red = 0; e_addr = 32'h0;
    if (rst) begin
      e_f1 = 1; e_f2 = 1;
    end else if (mp) begin
      e_f1 = 1; e_f2 = 1; e_red = 1;
      e_addr = bus.EX_taken_i ? bus.EX_PC_branch_i : bus.EX_PC_next_i;
    end else if (lu) begin
      e_pcw = 0; e_ifw = 0; e_noop = 1;
    end else if (bus.ID_Branch_i && pt) begin
      e_red = 1; e_f1 = 1; e_addr = bus.ID_PC_branch_i;
    end
    chk("pc_write",      32'(bus.pc_write_o),      32'(e_pcw));
    chk("if_id_write",   32'(bus.if_id_write_o),   32'(e_ifw));
    chk("id_noop",       32'(bus.id_noop_o),       32'(e_noop));
    chk("if_id_flush",   32'(bus.if_id_flush_o),   32'(e_f1));
    chk("id_ex_flush",   32'(bus.id_ex_flush_o),   32'(e_f2));
    chk("pc_redirect",   32'(bus.pc_redirect_o),   32'(e_red));
    chk("redirect_addr", bus.pc_redirect_addr_o,   e_addr);
    chk("predict_taken", 32'(bus.predict_taken_o), 32'(pt));
    chk("pred_state",    32'(bus.pred_state_o),    m_pred);
    chk("stall_cnt",     32'(bus.stall_cnt_o),     m_scnt);
    chk("mispred_cnt",   32'(bus.mispredict_cnt_o), m_mcnt);
    // Next model state, taken at the coming rising edge.
    nx_pred = m_pred; nx_scnt = m_scnt; nx_mcnt = m_mcnt;
    if (!rst) begin
      if (bus.EX_Branch_i) begin
        if (bus.EX_taken_i) nx_pred = (m_pred == 3) ? 3 : m_pred + 1;
        else                nx_pred = (m_pred == 0) ? 0 : m_pred - 1;
      end
      if (mp)      nx_mcnt = (m_mcnt < CNT_MAX) ? m_mcnt + 1 : CNT_MAX;
      else if (lu) nx_scnt = (m_scnt < CNT_MAX) ? m_scnt + 1 : CNT_MAX;
    end
  end

  // Model state register.
  always @(posedge clk) begin
    if (rst) begin
      m_pred = 2; m_scnt = 0; m_mcnt = 0;
    end else begin
      m_pred = nx_pred; m_scnt = nx_scnt; m_mcnt = nx_mcnt;
    end
  end

  task automatic idle();
    bus.ID_Branch_i         = 1'b0;
    bus.ID_RS1addr_i        = 5'd0;
    bus.ID_RS2addr_i        = 5'd0;
    bus.ID_PC_branch_i      = 32'h0;
    bus.EX_MemRead_i        = 1'b0;
    bus.EX_RDaddr_i         = 5'd0;
    bus.EX_Branch_i         = 1'b0;
    bus.EX_Predict_Branch_i = 1'b0;
    bus.EX_taken_i          = 1'b0;
    bus.EX_PC_next_i        = 32'h0;
    bus.EX_PC_branch_i      = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    // Held in reset.
    chk("rst if_id_flush", 32'(bus.if_id_flush_o), 32'd1);
    chk("rst id_ex_flush", 32'(bus.id_ex_flush_o), 32'd1);
    chk("rst pc_redirect", 32'(bus.pc_redirect_o), 32'd0);
    chk("rst pc_write",    32'(bus.pc_write_o),    32'd1);
    rst = 1'b0;
    #1;
    chk("idle pred_state",  32'(bus.pred_state_o),     32'd2);
    chk("idle predict",     32'(bus.predict_taken_o),  32'd1);
    chk("idle pc_write",    32'(bus.pc_write_o),       32'd1);
    chk("idle if_id_flush", 32'(bus.if_id_flush_o),    32'd0);
    chk("idle id_ex_flush", 32'(bus.id_ex_flush_o),    32'd0);
    chk("idle stall_cnt",   32'(bus.stall_cnt_o),      32'd0);
    chk("idle mispred_cnt", 32'(bus.mispredict_cnt_o), 32'd0);

    // Load-use on rs2.
    bus.EX_MemRead_i = 1'b1; bus.EX_RDaddr_i = 5'd5; bus.ID_RS2addr_i = 5'd5;
    #1;
    chk("lu pc_write",    32'(bus.pc_write_o),    32'd0);
    chk("lu if_id_write", 32'(bus.if_id_write_o), 32'd0);
    chk("lu id_noop",     32'(bus.id_noop_o),     32'd1);
    tick(); idle();
    chk("lu stall_cnt", 32'(bus.stall_cnt_o), 32'd1);

    // x0 destination never stalls.
    bus.EX_MemRead_i = 1'b1; bus.EX_RDaddr_i = 5'd0; bus.ID_RS1addr_i = 5'd0;
    #1;
    chk("x0 pc_write", 32'(bus.pc_write_o), 32'd1);
    chk("x0 id_noop",  32'(bus.id_noop_o),  32'd0);
    tick(); idle();
    chk("x0 stall_cnt", 32'(bus.stall_cnt_o), 32'd1);

    // Predicted taken, actually not taken.
    bus.EX_Branch_i = 1'b1; bus.EX_Predict_Branch_i = 1'b1; bus.EX_taken_i = 1'b0;
    bus.EX_PC_next_i = 32'h104; bus.EX_PC_branch_i = 32'h300;
    #1;
    chk("mp if_id_flush", 32'(bus.if_id_flush_o),  32'd1);
    chk("mp id_ex_flush", 32'(bus.id_ex_flush_o),  32'd1);
    chk("mp pc_redirect", 32'(bus.pc_redirect_o),  32'd1);
    chk("mp addr",        bus.pc_redirect_addr_o,  32'h104);
    tick(); idle();
    chk("mp mispred_cnt", 32'(bus.mispredict_cnt_o), 32'd1);
    chk("mp pred_state",  32'(bus.pred_state_o),     32'd1);

    // Mispredict and load-use together: mispredict wins.
    bus.EX_Branch_i = 1'b1; bus.EX_Predict_Branch_i = 1'b0; bus.EX_taken_i = 1'b1;
    bus.EX_PC_branch_i = 32'h200; bus.EX_PC_next_i = 32'h108;
    bus.EX_MemRead_i = 1'b1; bus.EX_RDaddr_i = 5'd3; bus.ID_RS1addr_i = 5'd3;
    #1;
    chk("mplu addr",     bus.pc_redirect_addr_o, 32'h200);
    chk("mplu pc_write", 32'(bus.pc_write_o),    32'd1);
    chk("mplu id_noop",  32'(bus.id_noop_o),     32'd0);
    chk("mplu flush",    32'(bus.id_ex_flush_o), 32'd1);
    tick(); idle();
    chk("mplu stall_cnt",   32'(bus.stall_cnt_o),      32'd1);
    chk("mplu mispred_cnt", 32'(bus.mispredict_cnt_o), 32'd2);
    chk("mplu pred_state",  32'(bus.pred_state_o),     32'd2);

    // Predictor saturation walk (correct predictions only).
    bus.EX_Branch_i = 1'b1; bus.EX_Predict_Branch_i = 1'b0; bus.EX_taken_i = 1'b0;
    tick();
    chk("walk to 01", 32'(bus.pred_state_o), 32'd1);
    bus.EX_Predict_Branch_i = 1'b1; bus.EX_taken_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("walk taken", 32'(bus.pred_state_o), exp_t[i]);
    end
    bus.EX_Predict_Branch_i = 1'b0; bus.EX_taken_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("walk not-taken", 32'(bus.pred_state_o), exp_n[i]);
    end
    idle();

    // Long load-use hold: stall counter saturates at 15.
    bus.EX_MemRead_i = 1'b1; bus.EX_RDaddr_i = 5'd7; bus.ID_RS2addr_i = 5'd7;
    for (int i = 0; i < 20; i++) tick();
    chk("sat stall_cnt", 32'(bus.stall_cnt_o), 32'd15);
    tick();
    chk("sat hold", 32'(bus.stall_cnt_o), 32'd15);

    // Asynchronous reset in the middle of a stall.
    #2;
    rst = 1'b1;
    #1;
    chk("arst stall_cnt",   32'(bus.stall_cnt_o),      32'd0);
    chk("arst mispred_cnt", 32'(bus.mispredict_cnt_o), 32'd0);
    chk("arst pc_write",    32'(bus.pc_write_o),       32'd1);
    chk("arst id_noop",     32'(bus.id_noop_o),        32'd0);
    chk("arst if_id_flush", 32'(bus.if_id_flush_o),    32'd1);
    chk("arst pc_redirect", 32'(bus.pc_redirect_o),    32'd0);
    chk("arst pred_state",  32'(bus.pred_state_o),     32'd2);
    tick();
    rst = 1'b0;
    #1;
    chk("post-rst pc_write",  32'(bus.pc_write_o),  32'd0);
    chk("post-rst stall_cnt", 32'(bus.stall_cnt_o), 32'd0);
    tick();
    chk("post-rst stall 1", 32'(bus.stall_cnt_o), 32'd1);
    idle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst                     = ($urandom_range(0, 99) == 0);
      bus.ID_Branch_i         = 1'($urandom_range(0, 1));
      bus.ID_RS1addr_i        = 5'($urandom_range(0, 3));
      bus.ID_RS2addr_i        = 5'($urandom_range(0, 3));
      bus.ID_PC_branch_i      = $urandom;
      bus.EX_MemRead_i        = 1'($urandom_range(0, 1));
      bus.EX_RDaddr_i         = 5'($urandom_range(0, 3));
      bus.EX_Branch_i         = 1'($urandom_range(0, 1));
      bus.EX_Predict_Branch_i = 1'($urandom_range(0, 1));
      bus.EX_taken_i          = 1'($urandom_range(0, 1));
      bus.EX_PC_next_i        = $urandom;
      bus.EX_PC_branch_i      = $urandom;
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and branch controller for the 5-stage pipeline. Drives stall, flush and PC redirect for the IF/ID and ID/EX pipeline registers.
- Detects load-use hazards against the instruction in ID.
- Makes a branch prediction in ID using a global 2-bit saturating predictor, resolves it when the branch reaches EX, and flushes wrong-path instructions on a mispredict.
- Keeps saturating performance counters for stalls and mispredicts.

Parameters:
- CNT_W, 16, width of the stall and mispredict performance counters.
- PRED_RST, 2'b10, predictor state loaded at reset (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ID_Branch_i  in  1  instruction in ID is a conditional branch.
- ID_RS1addr_i  in  5  rs1 of the instruction in ID.
- ID_RS2addr_i  in  5  rs2 of the instruction in ID.
- ID_PC_branch_i  in  32  branch target computed in ID.
- EX_MemRead_i  in  1  instruction in EX is a load.
- EX_RDaddr_i  in  5  rd of the instruction in EX.
- EX_Branch_i  in  1  instruction in EX is a branch.
- EX_Predict_Branch_i  in  1  prediction that was made for the branch now in EX.
- EX_taken_i  in  1  actual branch outcome, valid when EX_Branch_i=1.
- EX_PC_next_i  in  32  PC+4 of the branch in EX.
- EX_PC_branch_i  in  32  target of the branch in EX.
- pc_write_o  out  1  PC register load enable.
- if_id_write_o  out  1  IF/ID register load enable.
- id_noop_o  out  1  zero the control signals entering ID/EX (bubble).
- if_id_flush_o  out  1  flush IF/ID.
- id_ex_flush_o  out  1  flush ID/EX.
- predict_taken_o  out  1  current prediction, forwarded with the ID instruction into ID/EX.
- pc_redirect_o  out  1  select pc_redirect_addr_o as the next PC.
- pc_redirect_addr_o  out  32  redirect target.
- stall_cnt_o  out  CNT_W  number of load-use stall cycles.
- mispredict_cnt_o  out  CNT_W  number of resolved mispredicts.
- pred_state_o  out  2  predictor state, for debug.

Behaviour:
- State:
  - 2-bit predictor register; the two counters.
  - All control outputs are combinational from the inputs and this state; there is zero-cycle latency to the pipeline registers.
- Reset (rst_i=1, asynchronous):
  - predictor <= PRED_RST; both counters <= 0.
  - While rst_i is high, force pc_write_o=1, if_id_write_o=1, id_noop_o=0, if_id_flush_o=1, id_ex_flush_o=1, pc_redirect_o=0, pc_redirect_addr_o=0.
  - Reset asserted mid-operation discards any pending stall or redirect; the first cycle after deassertion evaluates fresh.
- mispredict = EX_Branch_i & (EX_Predict_Branch_i != EX_taken_i).
- loaduse = EX_MemRead_i & (EX_RDaddr_i != 0) & (EX_RDaddr_i == ID_RS1addr_i | EX_RDaddr_i == ID_RS2addr_i).
- predict_taken_o = predictor[1].
- Priority, highest first:
  1. mispredict:
     - if_id_flush_o=1, id_ex_flush_o=1, pc_redirect_o=1.
     - pc_redirect_addr_o = EX_taken_i ? EX_PC_branch_i : EX_PC_next_i.
     - pc_write_o=1. loaduse is ignored; the ID instruction is wrong-path.
  2. loaduse:
     - pc_write_o=0, if_id_write_o=0, id_noop_o=1.
     - No flushes, no redirect; a branch in ID is not redirected this cycle.
     - stall_cnt_o increments.
  3. ID_Branch_i & predict_taken_o:
     - pc_redirect_o=1, pc_redirect_addr_o=ID_PC_branch_i, if_id_flush_o=1.
  4. Otherwise: pc_write_o=1, if_id_write_o=1; all other control outputs 0; pc_redirect_addr_o=0.
- Predictor update:
  - Happens on the clock edge where EX_Branch_i=1, independent of stall.
  - taken: saturating +1 (11 stays 11). not taken: saturating -1 (00 stays 00).
  - The ID prediction in the same cycle uses the pre-update state.
- Counters:
  - Each increments by 1 per qualifying cycle and saturates at all-ones; there is no wrap.
  - A mispredict cycle increments mispredict_cnt_o only, even when loaduse is also true.
- Back-to-back load-use stalls are only possible if the inputs stay asserted. A single load-use hazard produces exactly one stall cycle, because ID/EX holds a bubble the next cycle.
- x0 never causes a stall.

Decomposition:
- Shared package pipe_pkg:
  - predictor state constants (SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11);
  - REG_ADDR_W=5, XLEN=32.
- One natural sub-module: sat_counter (parameterised width; inc, rst; saturating). It is instantiated twice for the performance counters.
- The predictor FSM stays inline.

Test Plan:
- Reset with PRED_RST=2'b10, then rst_i=0 and all inputs idle -> pred_state_o=10, predict_taken_o=1, pc_write_o=1, all flushes 0, both counters 0.
- EX_MemRead_i=1, EX_RDaddr_i=5, ID_RS2addr_i=5 for one cycle -> pc_write_o=0, if_id_write_o=0, id_noop_o=1; stall_cnt_o=1 after the edge. Repeat with EX_RDaddr_i=0 and ID_RS1addr_i=0 -> no stall.
- EX_Branch_i=1, EX_Predict_Branch_i=1, EX_taken_i=0, EX_PC_next_i=0x104 -> both flushes 1, pc_redirect_o=1, pc_redirect_addr_o=0x104, mispredict_cnt_o=1, predictor 10->01.
- Mispredict and loaduse in the same cycle -> flush and redirect to EX_PC_branch_i=0x200 when EX_taken_i=1; pc_write_o=1, id_noop_o=0; stall_cnt_o unchanged.
- Four taken branches from state 01 -> states 10, 11, 11, 11 (saturates). Then five not-taken -> 10, 01, 00, 00, 00.
- Force CNT_W=4 and hold loaduse for 20 cycles -> stall_cnt_o reaches 15 and stays at 15. Assert rst_i mid-stall -> counters 0 and outputs at reset values immediately, without waiting for a clock edge.
